pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised pong game engine: owns the game state machine, ball motion, paddle position, difficulty selection and BCD scoring for a COLS × ROWS LED matrix game. It sits between the key debouncers and the matrix scan/7-segment drivers. It generalises the fixed 5×7, single-speed game in geometry, paddle width, win score and speed. It adds difficulty-scaled ball speed, paddle saturation and a finished-screen blink.

## Interface
- COLS, 5: positions on the paddle axis (ball_x and paddle range); must be ≥ 2.
- ROWS, 7: ball travel depth; the paddle lies on row ROWS-1; must be ≥ 2.
- PADDLE_W, 1: paddle width in positions, 1..COLS.
- WIN_SCORE, 99: score that wins the game, 1..99.
- BLINK_TICKS, 4: ticks per blank toggle in FINISHED, ≥ 1.
- XW = $clog2(COLS) and YW = $clog2(ROWS) are derived, not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  game step strobe, one clk wide.
- key_sel  in  1  debounced select pulse, one clk wide.
- key_up  in  1  debounced up pulse, one clk wide.
- key_down  in  1  debounced down pulse, one clk wide.
- state  out  2  game state: 00 IN_MENU, 01 RUNNING, 10 PAUSED, 11 FINISHED.
- difficulty  out  2  0 (slowest) .. 3 (fastest).
- ball_x  out  XW  ball column.
- ball_y  out  YW  ball row.
- paddle  out  XW  lowest position covered by the paddle.
- score_units, score_tens  out  4 each  BCD score.
- won, lost  out  1 each  game result flags.
- blank  out  1  display blank request.

## Operation
- Reset (rst=0) puts every output and register at its reset value:
  - state=00, difficulty=0, ball_x=0, ball_y=0, dir_x=+1, dir_y=+1.
  - paddle=0, score=00, won=lost=0, blank=0.
  - step counter=0, blink counter=0.
- Key priority: key_sel > key_up > down. Only one key acts per cycle.
- IN_MENU:
  - key_up: difficulty+1, wrapping 3→0.
  - key_down: difficulty-1, wrapping 0→3.
  - key_sel: go to RUNNING. Ball, directions, paddle, score, won, lost and step counter return to their reset values.
- RUNNING:
  - key_up: paddle+1, saturating at COLS-PADDLE_W. key_down: paddle-1, saturating at 0. The move takes effect on that edge, independent of tick.
  - key_sel: go to PAUSED. If key_sel and a ball step fall on the same cycle, the pause wins and the step is not taken.
  - Each tick increments the step counter. The ball step period is P = 4 - difficulty ticks.
  - A tick that finds the counter at P-1 performs a ball step and clears the counter to 0.
- Ball step:
  - Move: x' = x + dir_x, y' = y + dir_y.
  - Direction update: x'=0 sets dir_x=+1; x'=COLS-1 sets dir_x=-1. y'=0 sets dir_y=+1.
  - Landing on y'=ROWS-1 is evaluated against the current paddle value.
  - Hit (paddle ≤ x' ≤ paddle+PADDLE_W-1): score+1 in BCD (units 9→0 carries into tens), dir_y=-1. If the new score equals WIN_SCORE: won=1 and go to FINISHED.
  - Miss: lost=1 and go to FINISHED. The ball stays at the landing position.
- PAUSED: the ball, the counters and the paddle are frozen.
  - key_sel: go to RUNNING; the step counter resumes where it stopped.
  - key_down: abandon; go to FINISHED with won=lost=0.
  - key_up: ignored.
- FINISHED:
  - blank toggles every BLINK_TICKS ticks.
  - Score, won and lost hold.
  - key_sel: go to IN_MENU with blank=0, won=lost=0 and the blink counter cleared. The score is kept until the next start.
- difficulty changes only in IN_MENU.

## Timing
- All outputs are registered. A key pulse or tick affects the outputs on the next rising clk edge.
- A ball step, the score increment, the won/lost flag and the state change all update on the same edge.
- Ball latency is P ticks from entering RUNNING or from the previous step.
- Reset is asynchronous on assert and synchronous on release. Asserting it mid-game forces IN_MENU immediately, with no completion of any pending update.

## Test plan
- Difficulty wrap: reset, key_down → difficulty=3; key_up ×2 → difficulty=1.
- Miss (COLS=5, ROWS=7, difficulty=3): key_sel, then 6 ticks.
  - Ball x path: 1,2,3,4,3,2. Ball y path: 1..6.
  - Paddle=0 at landing → lost=1, state=11, ball=(2,6), score=00.
- Hit: same setup with key_up ×2 before landing (paddle=2).
  - After tick 6: score_units=1, state=01.
  - Tick 7 → ball_y=5.
  - key_up ×5 → paddle saturates at 4.
- Pause and speed (difficulty=0): key_sel, 2 ticks, key_sel → state=10.
  - 20 ticks → ball unchanged at (0,0).
  - key_sel, then 2 ticks → ball=(1,1).
  - Abandon path: key_sel, key_down → state=11, won=lost=0.
- Win and blink (WIN_SCORE=1, BLINK_TICKS=4, PADDLE_W=5): first landing → won=1, state=11.
  - blank rises after 4 ticks and falls after 8 ticks.
  - key_sel → state=00, blank=0, score=01.
- Async reset: drive rst=0 mid-RUNNING between clk edges → state=00 and all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pong_engine.sv
// Pong game engine for a COLS x ROWS LED matrix: game FSM, ball motion,
// paddle, difficulty selection, BCD scoring and finished-screen blink.
module pong_engine #(
  parameter  int unsigned COLS        = 5,
  parameter  int unsigned ROWS        = 7,
  parameter  int unsigned PADDLE_W    = 1,
  parameter  int unsigned WIN_SCORE   = 99,
  parameter  int unsigned BLINK_TICKS = 4,
  localparam int unsigned XW          = $clog2(COLS),
  localparam int unsigned YW          = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          key_sel,
  input  logic          key_up,
  input  logic          key_down,
  output logic [1:0]    state,
  output logic [1:0]    difficulty,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic [XW-1:0] paddle,
  output logic [3:0]    score_units,
  output logic [3:0]    score_tens,
  output logic          won,
  output logic          lost,
  output logic          blank
);

  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [XW-1:0] X_ONE      = XW'(1);
  localparam logic [XW-1:0] X_MAX      = XW'(COLS - 1);
  localparam logic [XW-1:0] PAD_MAX    = XW'(COLS - PADDLE_W);
  localparam logic [XW:0]   PAD_SPAN   = (XW+1)'(PADDLE_W - 1);
  localparam logic [YW-1:0] Y_ONE      = YW'(1);
  localparam logic [YW-1:0] Y_MAX      = YW'(ROWS - 1);
  localparam logic [3:0]    WIN_TENS   = 4'(WIN_SCORE / 10);
  localparam logic [3:0]    WIN_UNITS  = 4'(WIN_SCORE % 10);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IN_MENU  = 2'b00,
    RUNNING  = 2'b01,
    PAUSED   = 2'b10,
    FINISHED = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    diff_q, diff_d;
  logic [XW-1:0] ball_x_q, ball_x_d;
  logic [YW-1:0] ball_y_q, ball_y_d;
  logic          dir_x_q, dir_x_d;   // 1 = +1, 0 = -1
  logic          dir_y_q, dir_y_d;
  logic [XW-1:0] paddle_q, paddle_d;
  logic [3:0]    units_q, units_d;
  logic [3:0]    tens_q, tens_d;
  logic          won_q, won_d;
  logic          lost_q, lost_d;
  logic          blank_q, blank_d;
  logic [1:0]    step_cnt_q, step_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  logic [XW-1:0] x_step;
  logic [YW-1:0] y_step;
  logic [1:0]    step_last;
  logic          hit;
  logic [3:0]    units_inc, tens_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IN_MENU;
      diff_q      <= '0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      paddle_q    <= '0;
      units_q     <= '0;
      tens_q      <= '0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      blank_q     <= 1'b0;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      diff_q      <= diff_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      paddle_q    <= paddle_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
      blank_q     <= blank_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    diff_d      = diff_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    paddle_d    = paddle_q;
    units_d     = units_q;
    tens_d      = tens_q;
    won_d       = won_q;
    lost_d      = lost_q;
    blank_d     = blank_q;
    step_cnt_d  = step_cnt_q;
    blink_cnt_d = blink_cnt_q;

    x_step    = dir_x_q ? (ball_x_q + X_ONE) : (ball_x_q - X_ONE);
    y_step    = dir_y_q ? (ball_y_q + Y_ONE) : (ball_y_q - Y_ONE);
    // period P = 4 - difficulty, so the last counter value is 3 - difficulty
    step_last = 2'd3 - diff_q;
    // landing is judged against the paddle before any same-cycle move
    hit       = ({1'b0, x_step} >= {1'b0, paddle_q}) &&
                ({1'b0, x_step} <= ({1'b0, paddle_q} + PAD_SPAN));
    if (units_q == 4'd9) begin
      units_inc = 4'd0;
      tens_inc  = tens_q + 4'd1;
    end else begin
      units_inc = units_q + 4'd1;
      tens_inc  = tens_q;
    end

    unique case (state_q)
      IN_MENU: begin
        if (key_sel) begin
          state_d    = RUNNING;
          ball_x_d   = '0;
          ball_y_d   = '0;
          dir_x_d    = 1'b1;
          dir_y_d    = 1'b1;
          paddle_d   = '0;
          units_d    = '0;
          tens_d     = '0;
          won_d      = 1'b0;
          lost_d     = 1'b0;
          step_cnt_d = '0;
        end else if (key_up) begin
          diff_d = diff_q + 2'd1;
        end else if (key_down) begin
          diff_d = diff_q - 2'd1;
        end
      end

      RUNNING: begin
        if (key_sel) begin
          state_d = PAUSED;
        end else begin
          if (key_up) begin
            if (paddle_q < PAD_MAX) paddle_d = paddle_q + X_ONE;
          end else if (key_down) begin
            if (paddle_q != '0) paddle_d = paddle_q - X_ONE;
          end

          if (tick) begin
            if (step_cnt_q == step_last) begin
              step_cnt_d = '0;
              ball_x_d   = x_step;
              ball_y_d   = y_step;
              if (x_step == '0) dir_x_d = 1'b1;
              else if (x_step == X_MAX) dir_x_d = 1'b0;
              if (y_step == '0) dir_y_d = 1'b1;
              if (y_step == Y_MAX) begin
                if (hit) begin
                  units_d = units_inc;
                  tens_d  = tens_inc;
                  dir_y_d = 1'b0;
                  if (units_inc == WIN_UNITS && tens_inc == WIN_TENS) begin
                    won_d   = 1'b1;
                    state_d = FINISHED;
                  end
                end else begin
                  lost_d  = 1'b1;
                  state_d = FINISHED;
                end
              end
            end else begin
              step_cnt_d = step_cnt_q + 2'd1;
            end
          end
        end
      end

      PAUSED: begin
        if (key_sel) begin
          state_d = RUNNING;
        end else if (key_down) begin
          state_d = FINISHED;
          won_d   = 1'b0;
          lost_d  = 1'b0;
        end
      end

      FINISHED: begin
        if (key_sel) begin
          state_d     = IN_MENU;
          blank_d     = 1'b0;
          won_d       = 1'b0;
          lost_d      = 1'b0;
          blink_cnt_d = '0;
        end else if (tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
      end

      default: state_d = IN_MENU;
    endcase
  end

  assign state       = state_q;
  assign difficulty  = diff_q;
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign paddle      = paddle_q;
  assign score_units = units_q;
  assign score_tens  = tens_q;
  assign won         = won_q;
  assign lost        = lost_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: a default instance plus a one-point-win,
// full-width-paddle instance sharing clock, reset and key/tick inputs.
module tb_pong_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic key_sel = 1'b0;
  logic key_up = 1'b0;
  logic key_down = 1'b0;

  logic [1:0] state, difficulty;
  logic [2:0] ball_x, paddle;
  logic [2:0] ball_y;
  logic [3:0] score_units, score_tens;
  logic       won, lost, blank;

  logic [1:0] w_state, w_difficulty;
  logic [2:0] w_ball_x, w_paddle;
  logic [2:0] w_ball_y;
  logic [3:0] w_score_units, w_score_tens;
  logic       w_won, w_lost, w_blank;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_engine u_dut (
    .clk(clk), .rst(rst), .tick(tick),
    .key_sel(key_sel), .key_up(key_up), .key_down(key_down),
    .state(state), .difficulty(difficulty),
    .ball_x(ball_x), .ball_y(ball_y), .paddle(paddle),
    .score_units(score_units), .score_tens(score_tens),
    .won(won), .lost(lost), .blank(blank)
  );

  pong_engine #(.PADDLE_W(5), .WIN_SCORE(1), .BLINK_TICKS(4)) u_win (
    .clk(clk), .rst(rst), .tick(tick),
    .key_sel(key_sel), .key_up(key_up), .key_down(key_down),
    .state(w_state), .difficulty(w_difficulty),
    .ball_x(w_ball_x), .ball_y(w_ball_y), .paddle(w_paddle),
    .score_units(w_score_units), .score_tens(w_score_tens),
    .won(w_won), .lost(w_lost), .blank(w_blank)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pulses launch on a falling edge and are sampled on the next falling edge
  task automatic pulse_sel();
    @(negedge clk) key_sel = 1'b1;
    @(negedge clk) key_sel = 1'b0;
  endtask
  task automatic pulse_up();
    @(negedge clk) key_up = 1'b1;
    @(negedge clk) key_up = 1'b0;
  endtask
  task automatic pulse_down();
    @(negedge clk) key_down = 1'b1;
    @(negedge clk) key_down = 1'b0;
  endtask
  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  int unsigned exp_x[6] = '{1, 2, 3, 4, 3, 2};

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_diff", 32'(difficulty), 0);
    chk("rst_ball_x", 32'(ball_x), 0);
    chk("rst_ball_y", 32'(ball_y), 0);
    chk("rst_paddle", 32'(paddle), 0);
    chk("rst_score", 32'({score_tens, score_units}), 0);
    chk("rst_flags", 32'({won, lost, blank}), 0);
    rst = 1'b1;
    @(negedge clk);

    // difficulty wrap
    pulse_down();
    chk("diff_wrap_down", 32'(difficulty), 3);
    pulse_up();
    pulse_up();
    chk("diff_wrap_up", 32'(difficulty), 1);
    pulse_up();
    pulse_up();
    chk("diff_fast", 32'(difficulty), 3);

    // miss at difficulty 3 (one step per tick)
    pulse_sel();
    chk("start_state", 32'(state), 1);
    for (int i = 0; i < 6; i++) begin
      pulse_tick(1);
      chk("miss_x", 32'(ball_x), 32'(exp_x[i]));
      chk("miss_y", 32'(ball_y), 32'(i + 1));
    end
    chk("miss_lost", 32'(lost), 1);
    chk("miss_won", 32'(won), 0);
    chk("miss_state", 32'(state), 3);
    chk("miss_score", 32'({score_tens, score_units}), 0);

    // full-width paddle with win score 1 wins on the same landing
    chk("win_won", 32'(w_won), 1);
    chk("win_state", 32'(w_state), 3);
    chk("win_score", 32'({w_score_tens, w_score_units}), 1);
    pulse_tick(3);
    chk("blink_before", 32'(w_blank), 0);
    pulse_tick(1);
    chk("blink_rise", 32'(w_blank), 1);
    pulse_tick(3);
    chk("blink_hold", 32'(w_blank), 1);
    pulse_tick(1);
    chk("blink_fall", 32'(w_blank), 0);
    chk("fin_score_hold", 32'({w_score_tens, w_score_units}), 1);
    pulse_sel();
    chk("win_menu_state", 32'(w_state), 0);
    chk("win_menu_blank", 32'(w_blank), 0);
    chk("win_menu_won", 32'(w_won), 0);
    chk("win_menu_score", 32'({w_score_tens, w_score_units}), 1);
    chk("miss_menu_state", 32'(state), 0);
    chk("miss_menu_lost", 32'(lost), 0);

    // hit with paddle moved to 2 before landing
    pulse_sel();
    pulse_up();
    pulse_up();
    chk("hit_paddle", 32'(paddle), 2);
    chk("wide_paddle_sat", 32'(w_paddle), 0);
    pulse_tick(6);
    chk("hit_units", 32'(score_units), 1);
    chk("hit_tens", 32'(score_tens), 0);
    chk("hit_state", 32'(state), 1);
    chk("hit_ball", 32'({ball_x, ball_y}), 32'({3'd2, 3'd6}));
    pulse_tick(1);
    chk("rebound_y", 32'(ball_y), 5);
    chk("rebound_x", 32'(ball_x), 1);
    repeat (5) pulse_up();
    chk("paddle_sat_hi", 32'(paddle), 4);
    repeat (6) pulse_down();
    chk("paddle_sat_lo", 32'(paddle), 0);

    // pause and speed at difficulty 0
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    chk("rerst_diff", 32'(difficulty), 0);
    pulse_sel();
    pulse_tick(2);
    pulse_sel();
    chk("pause_state", 32'(state), 2);
    pulse_tick(20);
    chk("pause_ball", 32'({ball_x, ball_y}), 0);
    pulse_up();
    chk("pause_paddle", 32'(paddle), 0);
    pulse_sel();
    chk("resume_state", 32'(state), 1);
    pulse_tick(1);
    chk("resume_ball_hold", 32'({ball_x, ball_y}), 0);
    pulse_tick(1);
    chk("resume_step", 32'({ball_x, ball_y}), 32'({3'd1, 3'd1}));

    // key_sel and a due step on the same cycle: pause wins
    pulse_tick(3);
    @(negedge clk) begin key_sel = 1'b1; tick = 1'b1; end
    @(negedge clk) begin key_sel = 1'b0; tick = 1'b0; end
    chk("sel_vs_step_state", 32'(state), 2);
    chk("sel_vs_step_ball", 32'({ball_x, ball_y}), 32'({3'd1, 3'd1}));
    pulse_sel();
    pulse_tick(1);
    chk("deferred_step", 32'({ball_x, ball_y}), 32'({3'd2, 3'd2}));

    // abandon from pause
    pulse_sel();
    pulse_down();
    chk("abandon_state", 32'(state), 3);
    chk("abandon_flags", 32'({won, lost}), 0);

    // asynchronous reset between edges
    pulse_sel();
    pulse_sel();
    pulse_up();
    pulse_tick(4);
    chk("pre_rst_state", 32'(state), 1);
    chk("pre_rst_ball", 32'({ball_x, ball_y}), 32'({3'd1, 3'd1}));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_ball", 32'({ball_x, ball_y}), 0);
    chk("async_paddle", 32'(paddle), 0);
    chk("async_score", 32'({score_tens, score_units}), 0);
    chk("async_flags", 32'({won, lost, blank}), 0);
    @(negedge clk) rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
